// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer for the 16-bit control core: owns pc and the instruction register,
// and issues one commit per fetched instruction after any FFT/memory/sync stall clears.
module instr_sequencer #(
   parameter int PC_W = 12
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic            imem_rd_en,
   output logic [PC_W-1:0] imem_addr,
   input  logic [15:0]     imem_rdata,
   output logic [15:0]     instr,
   input  logic            dec_halt,
   input  logic            dec_branch,
   input  logic            dec_syn,
   input  logic            dec_fft_wr_en,
   input  logic            dec_mem_wr_en,
   input  logic [10:0]     dec_imm,
   input  logic            branch_cond,
   input  logic            fft_ready,
   input  logic            fft_busy,
   input  logic            mem_ready,
   output logic            commit,
   output logic            running,
   output logic            halted,
   output logic [PC_W-1:0] pc,
   output logic [2:0]      fsm_state
);

   // fsm_state debug encoding: IDLE=0 FETCH=1 EXEC=2 WAIT_FFT=3 WAIT_MEM=4 SYNC=5 HALTED=6
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_FETCH    = 3'd1,
      S_EXEC     = 3'd2,
      S_WAIT_FFT = 3'd3,
      S_WAIT_MEM = 3'd4,
      S_SYNC     = 3'd5,
      S_HALTED   = 3'd6
   } state_t;

   state_t          state;
   state_t          next_state;
   logic            pc_adv;
   logic            pc_take;
   logic            pc_clear;
   logic            instr_load;
   logic [PC_W-1:0] imm_ext;
   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] pc_target;

   // Handshakes: the instruction in instr is the 'valid' side and stays put; fft_ready,
   // mem_ready or !fft_busy is the 'ready' side; commit marks the single cycle both hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:     if (start) next_state = S_FETCH;
         S_FETCH:    next_state = S_EXEC;
         S_EXEC: begin
            if (dec_halt)           next_state = S_HALTED;
            else if (dec_branch)    next_state = S_FETCH;
            else if (dec_fft_wr_en) next_state = fft_ready ? S_FETCH : S_WAIT_FFT;
            else if (dec_mem_wr_en) next_state = mem_ready ? S_FETCH : S_WAIT_MEM;
            else if (dec_syn)       next_state = fft_busy ? S_SYNC : S_FETCH;
            else                    next_state = S_FETCH;
         end
         S_WAIT_FFT: if (fft_ready) next_state = S_FETCH;
         S_WAIT_MEM: if (mem_ready) next_state = S_FETCH;
         S_SYNC:     if (!fft_busy) next_state = S_FETCH;
         S_HALTED:   if (start) next_state = S_FETCH;
         default:    next_state = S_IDLE;
      endcase
   end

   always_comb begin
      imem_rd_en = 1'b0;
      commit     = 1'b0;
      running    = 1'b0;
      halted     = 1'b0;
      pc_adv     = 1'b0;
      pc_take    = 1'b0;
      pc_clear   = 1'b0;
      instr_load = 1'b0;
      case (state)
         S_FETCH: begin
            imem_rd_en = 1'b1;
            running    = 1'b1;
            instr_load = 1'b1;
         end
         S_EXEC: begin
            running = 1'b1;
            if (dec_halt) begin
               commit = 1'b1;
            end else if (dec_branch) begin
               commit  = 1'b1;
               pc_adv  = 1'b1;
               pc_take = branch_cond;
            end else if (dec_fft_wr_en) begin
               commit = fft_ready;
               pc_adv = fft_ready;
            end else if (dec_mem_wr_en) begin
               commit = mem_ready;
               pc_adv = mem_ready;
            end else if (dec_syn) begin
               commit = !fft_busy;
               pc_adv = !fft_busy;
            end else begin
               commit = 1'b1;
               pc_adv = 1'b1;
            end
         end
         S_WAIT_FFT: begin
            running = 1'b1;
            commit  = fft_ready;
            pc_adv  = fft_ready;
         end
         S_WAIT_MEM: begin
            running = 1'b1;
            commit  = mem_ready;
            pc_adv  = mem_ready;
         end
         S_SYNC: begin
            running = 1'b1;
            commit  = !fft_busy;
            pc_adv  = !fft_busy;
         end
         S_HALTED: begin
            halted   = 1'b1;
            pc_clear = start;
         end
         default: ;
      endcase
   end

   // Branch offset is 11-bit two's complement; narrow PCs just keep the low bits.
   if (PC_W > 11) begin : g_sext_wide
      assign imm_ext = {{(PC_W-11){dec_imm[10]}}, dec_imm};
   end else begin : g_sext_narrow
      assign imm_ext = dec_imm[PC_W-1:0];
   end

   assign pc_inc    = pc + PC_W'(1);
   assign pc_target = pc_inc + imm_ext;
   assign imem_addr = pc;
   assign fsm_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc    <= '0;
         instr <= '0;
      end else if (pc_clear) begin
         pc    <= '0;
         instr <= '0;
      end else begin
         if (pc_adv)     pc    <= pc_take ? pc_target : pc_inc;
         if (instr_load) instr <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a transaction-level model checks every cycle, and directed
// programs pin commit timing, branch targets, stalls, reset and PC wrap with literal values.
module tb_instr_sequencer;

   localparam int PC_W  = 12;
   localparam int PC_W4 = 4;
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_HALT = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic            start;
   logic            imem_rd_en;
   logic [PC_W-1:0] imem_addr;
   logic [15:0]     imem_rdata;
   logic [15:0]     instr;
   logic            dec_halt, dec_branch, dec_syn, dec_fft_wr_en, dec_mem_wr_en;
   logic [10:0]     dec_imm;
   logic            branch_cond, fft_ready, fft_busy, mem_ready;
   logic            commit, running, halted;
   logic [PC_W-1:0] pc;
   logic [2:0]      state_dbg;
   logic [15:0]     mem [0:(1<<PC_W)-1];

   // Instruction word layout: [15] halt [14] branch [13] fft write [12] mem write [11] sync
   assign dec_halt      = instr[15];
   assign dec_branch    = instr[14];
   assign dec_fft_wr_en = instr[13];
   assign dec_mem_wr_en = instr[12];
   assign dec_syn       = instr[11];
   assign dec_imm       = instr[10:0];
   // Memory data is only meaningful while the strobe is up; a poison word otherwise.
   assign imem_rdata    = imem_rd_en ? mem[imem_addr] : 16'hF00D;

   instr_sequencer #(.PC_W(PC_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .instr(instr),
      .dec_halt(dec_halt), .dec_branch(dec_branch), .dec_syn(dec_syn),
      .dec_fft_wr_en(dec_fft_wr_en), .dec_mem_wr_en(dec_mem_wr_en), .dec_imm(dec_imm),
      .branch_cond(branch_cond), .fft_ready(fft_ready), .fft_busy(fft_busy),
      .mem_ready(mem_ready),
      .commit(commit), .running(running), .halted(halted), .pc(pc),
      .fsm_state(state_dbg)
   );

   // Narrow-PC instance for the wrap/restart case.
   logic             start4, rd4, commit4, running4, halted4;
   logic [PC_W4-1:0] addr4, pc4;
   logic [15:0]      rdata4, instr4;
   logic [2:0]       state4;
   logic [15:0]      mem4 [0:15];

   assign rdata4 = rd4 ? mem4[addr4] : 16'hF00D;

   instr_sequencer #(.PC_W(PC_W4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4),
      .imem_rd_en(rd4), .imem_addr(addr4), .imem_rdata(rdata4),
      .instr(instr4),
      .dec_halt(instr4[15]), .dec_branch(instr4[14]), .dec_syn(instr4[11]),
      .dec_fft_wr_en(instr4[13]), .dec_mem_wr_en(instr4[12]), .dec_imm(instr4[10:0]),
      .branch_cond(1'b0), .fft_ready(1'b1), .fft_busy(1'b0), .mem_ready(1'b1),
      .commit(commit4), .running(running4), .halted(halted4), .pc(pc4),
      .fsm_state(state4)
   );

   int checks   = 0;
   int failures = 0;

   int          mode;
   int          m_pc;
   logic [15:0] m_instr;
   logic        pending;
   logic [15:0] p_word;
   logic        prev_commit;
   logic        exp_c;
   int          since_start;
   int          fetch_addr_q[$];
   int          fetch_cyc_q[$];
   int          commit_cyc_q[$];
   int          fetch4_q[$];
   logic [31:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Whether an instruction may retire this cycle, from the dispatch priority rules.
   function automatic logic may_commit(input logic [15:0] w);
      if (w[15] || w[14]) return 1'b1;
      if (w[13])          return fft_ready;
      if (w[12])          return mem_ready;
      if (w[11])          return !fft_busy;
      return 1'b1;
   endfunction

   function automatic int after_pc(input logic [15:0] w, input int cur);
      int imm;
      int t;
      if (w[15]) return cur;
      t = cur + 1;
      if (w[14] && branch_cond) begin
         imm = int'(w[10:0]);
         if (w[10]) imm = imm - 2048;
         t = cur + 1 + imm;
      end
      return ((t % (1 << PC_W)) + (1 << PC_W)) % (1 << PC_W);
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         mode = M_IDLE; m_pc = 0; m_instr = 16'h0; pending = 1'b0; prev_commit = 1'b0;
         chk("rst_commit", commit, 0);
         chk("rst_rd_en", imem_rd_en, 0);
         chk("rst_running", running, 0);
         chk("rst_halted", halted, 0);
         chk("rst_pc", pc, 0);
         chk("rst_instr", instr, 0);
         chk("rst_state", state_dbg, 0);
      end else begin
         since_start++;
         chk("pc", pc, m_pc);
         chk("instr", instr, m_instr);
         chk("running", running, mode == M_RUN);
         chk("halted", halted, mode == M_HALT);
         chk("commit_back_to_back", commit & prev_commit, 0);
         prev_commit = commit;
         if (mode != M_RUN) begin
            chk("idle_rd_en", imem_rd_en, 0);
            chk("idle_commit", commit, 0);
            if (start) begin
               mode = M_RUN; m_pc = 0; m_instr = 16'h0; since_start = 0;
            end
         end else if (!pending) begin
            chk("fetch_rd_en", imem_rd_en, 1);
            chk("fetch_addr", imem_addr, m_pc);
            chk("fetch_commit", commit, 0);
            fetch_addr_q.push_back(int'(imem_addr));
            fetch_cyc_q.push_back(since_start);
            pending = 1'b1;
            p_word  = mem[m_pc];
            m_instr = p_word;
         end else begin
            chk("stall_rd_en", imem_rd_en, 0);
            exp_c = may_commit(p_word);
            chk("commit", commit, exp_c);
            if (commit) commit_cyc_q.push_back(since_start);
            if (exp_c) begin
               pending = 1'b0;
               m_pc    = after_pc(p_word, m_pc);
               if (p_word[15]) mode = M_HALT;
            end
         end
      end
   end

   always @(negedge clk) if (rst_n && rd4) fetch4_q.push_back(int'(addr4));

   function automatic int q_at(input int which, input int idx);
      case (which)
         0:       return (idx < fetch_addr_q.size()) ? fetch_addr_q[idx] : -1;
         1:       return (idx < fetch_cyc_q.size()) ? fetch_cyc_q[idx] : -1;
         2:       return (idx < commit_cyc_q.size()) ? commit_cyc_q[idx] : -1;
         default: return (idx < fetch4_q.size()) ? fetch4_q[idx] : -1;
      endcase
   endfunction

   task automatic check_log(input string name, input int which);
      int n;
      n = (which == 0) ? fetch_addr_q.size() : (which == 1) ? fetch_cyc_q.size() :
          (which == 2) ? commit_cyc_q.size() : fetch4_q.size();
      chk({name, "_len"}, n, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         chk($sformatf("%s[%0d]", name, i), q_at(which, i), exp_q[i]);
   endtask

   task automatic clear_logs();
      fetch_addr_q.delete(); fetch_cyc_q.delete(); commit_cyc_q.delete();
   endtask

   task automatic clear_mem();
      for (int i = 0; i < (1 << PC_W); i++) mem[i] = 16'h0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b1; start = 1'b0; start4 = 1'b0;
      branch_cond = 1'b0; fft_ready = 1'b1; fft_busy = 1'b0; mem_ready = 1'b1;
      clear_mem();
      for (int i = 0; i < 16; i++) mem4[i] = 16'h0055;
      #1 rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      chk("idle_after_reset_running", running, 0);

      // Straight-line code with a stray start mid-run, halt at 3.
      mem[0] = 16'h0011; mem[1] = 16'h0022; mem[2] = 16'h0033; mem[3] = 16'h8000;
      clear_logs();
      pulse_start();
      for (int k = 1; k <= 12; k++) begin
         start = (k == 3 || k == 4);
         tick();
      end
      start = 1'b0;
      exp_q = '{2, 4, 6, 8};    check_log("line_commit_cyc", 2);
      exp_q = '{0, 1, 2, 3};    check_log("line_fetch_addr", 0);
      chk("line_halted", halted, 1);
      chk("line_pc", pc, 3);

      // Backward branch taken once, then not taken; all-flags word halts.
      clear_mem();
      for (int i = 0; i < 5; i++) mem[i] = 16'h0100 + 16'(i);
      mem[5] = 16'h47FE; mem[6] = 16'hF800;
      clear_logs();
      branch_cond = 1'b1;
      pulse_start();
      for (int k = 0; k < 40 && commit_cyc_q.size() < 6; k++) tick();
      chk("branch_wait", commit_cyc_q.size() >= 6, 1);
      branch_cond = 1'b0;
      for (int k = 0; k < 40 && !halted; k++) tick();
      chk("branch_halt_wait", halted, 1);
      exp_q = '{0, 1, 2, 3, 4, 5, 4, 5, 6}; check_log("branch_fetch_addr", 0);
      chk("branch_pc", pc, 6);

      // FFT stall, memory stall, sync stall, sync without stall, fft+mem priority, halt.
      clear_mem();
      mem[0] = 16'h2000; mem[1] = 16'h1000; mem[2] = 16'h0800; mem[3] = 16'h0800;
      mem[4] = 16'h3000; mem[5] = 16'h8000;
      clear_logs();
      pulse_start();
      for (int k = 1; k <= 26; k++) begin
         fft_ready = !(k >= 2 && k <= 4);
         mem_ready = !((k >= 7 && k <= 8) || k == 20);
         fft_busy  = (k >= 11 && k <= 15);
         tick();
      end
      fft_ready = 1'b1; mem_ready = 1'b1; fft_busy = 1'b0;
      exp_q = '{5, 9, 16, 18, 20, 22}; check_log("stall_commit_cyc", 2);
      exp_q = '{1, 6, 10, 17, 19, 21}; check_log("stall_fetch_cyc", 1);
      exp_q = '{0, 1, 2, 3, 4, 5};     check_log("stall_fetch_addr", 0);
      chk("stall_pc", pc, 5);

      // Reset while waiting on data memory.
      clear_mem();
      mem[0] = 16'h1000; mem[1] = 16'h8000;
      clear_logs();
      mem_ready = 1'b0;
      pulse_start();
      for (int k = 1; k <= 3; k++) tick();
      #1 rst_n = 1'b0;
      #1;
      chk("async_commit", commit, 0);
      chk("async_rd_en", imem_rd_en, 0);
      chk("async_running", running, 0);
      chk("async_halted", halted, 0);
      chk("async_pc", pc, 0);
      chk("async_instr", instr, 0);
      mem_ready = 1'b1;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      chk("reset_no_commit", commit_cyc_q.size(), 0);
      chk("reset_no_autostart", running, 0);
      clear_logs();
      pulse_start();
      for (int k = 1; k <= 8; k++) tick();
      exp_q = '{0, 1}; check_log("rst_fetch_addr", 0);
      exp_q = '{2, 4}; check_log("rst_commit_cyc", 2);

      // Four-bit PC wrap, halt, restart.
      fetch4_q.delete();
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      for (int k = 0; k < 80 && fetch4_q.size() < 16; k++) tick();
      chk("wrap_wait", fetch4_q.size() >= 16, 1);
      mem4[1] = 16'h8000;
      for (int k = 0; k < 20 && !halted4; k++) tick();
      chk("wrap_halted", halted4, 1);
      chk("wrap_state", state4, 6);
      chk("wrap_pc", pc4, 1);
      exp_q = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 0, 1};
      check_log("wrap_fetch_addr", 3);
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      repeat (3) tick();
      chk("restart_fetch_addr", q_at(3, 18), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
